// File: rtl/prs_lfsr_gen_if.sv
// Bundle of control, seed and status signals for the pseudo-random sequence generator.
// The master drives step/load/seed and the slave (the generator) drives state and status.
interface prs_lfsr_gen_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] prs;
    logic             prs_bit;
    logic             wrap;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             lockup;

    modport master (
        output en, load, seed,
        input  prs, prs_bit, wrap, period, period_valid, lockup
    );

    modport slave (
        input  en, load, seed,
        output prs, prs_bit, wrap, period, period_valid, lockup
    );
endinterface

// File: rtl/prs_lfsr_gen.sv
// Fibonacci XNOR LFSR with seed load, lock-up recovery and on-line period measurement.
// State shifts toward the MSB; feedback enters at bit 0 and prs_bit is the MSB.
module prs_lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic          CLK,
    input  logic          RST,
    prs_lfsr_gen_if.slave bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] prs_r;
    logic [WIDTH-1:0] start_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] period_r;
    logic             period_valid_r;
    logic             wrap_r;
    logic             lockup_r;

    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] cnt_inc_s;
    logic             locked_s;
    logic             cnt_sat_s;

    // XNOR of the tapped state bits; all-ones keeps it at 1, hence the lock-up state.
    function automatic logic feedback(input logic [WIDTH-1:0] state);
        return ~(^(state & TAPS));
    endfunction

    // Next-state and counter arithmetic for the normal step.
    always_comb begin
        next_s    = {prs_r[WIDTH-2:0], feedback(prs_r)};
        cnt_inc_s = cnt_r + ONE;
        locked_s  = (prs_r == ALL_ONES);
        cnt_sat_s = (cnt_r == ALL_ONES);
    end

    // State, measurement and pulse registers; load beats en, lock-up beats a normal step.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prs_r          <= ZERO;
            start_r        <= ZERO;
            cnt_r          <= ZERO;
            period_r       <= ZERO;
            period_valid_r <= 1'b0;
            wrap_r         <= 1'b0;
            lockup_r       <= 1'b0;
        end else if (bus.load) begin
            prs_r          <= bus.seed;
            start_r        <= bus.seed;
            cnt_r          <= ZERO;
            period_valid_r <= 1'b0;
            wrap_r         <= 1'b0;
            lockup_r       <= 1'b0;
        end else if (bus.en) begin
            if (locked_s) begin
                // Escape to the reset state instead of stepping; the measurement restarts there.
                prs_r          <= ZERO;
                start_r        <= ZERO;
                cnt_r          <= ZERO;
                period_valid_r <= 1'b0;
                wrap_r         <= 1'b0;
                lockup_r       <= 1'b1;
            end else begin
                prs_r    <= next_s;
                lockup_r <= 1'b0;
                if (next_s == start_r) begin
                    wrap_r         <= 1'b1;
                    period_r       <= cnt_inc_s;
                    period_valid_r <= 1'b1;
                    cnt_r          <= ZERO;
                end else begin
                    wrap_r <= 1'b0;
                    // A start state on a transient tail never recurs, so the count must not wrap.
                    if (!cnt_sat_s) begin
                        cnt_r <= cnt_inc_s;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
            end
        end else begin
            wrap_r   <= 1'b0;
            lockup_r <= 1'b0;
        end
    end

    assign bus.prs          = prs_r;
    assign bus.prs_bit      = prs_r[WIDTH-1];
    assign bus.wrap         = wrap_r;
    assign bus.period       = period_r;
    assign bus.period_valid = period_valid_r;
    assign bus.lockup       = lockup_r;

endmodule

// File: tb/tb_prs_lfsr_gen.sv
// Directed bench for prs_lfsr_gen: a maximal-tap instance and a non-maximal (8'h0C) instance.
module tb_prs_lfsr_gen;
    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   passes = 0;

    always #5 CLK = ~CLK;

    prs_lfsr_gen_if #(.WIDTH(8)) bus ();
    prs_lfsr_gen_if #(.WIDTH(8)) bus2 ();

    prs_lfsr_gen #(.WIDTH(8), .TAPS(8'hB8)) dut  (.CLK(CLK), .RST(RST), .bus(bus));
    prs_lfsr_gen #(.WIDTH(8), .TAPS(8'h0C)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

    // Reference step written bit by bit from the feedback rule.
    function automatic logic [7:0] nxt(input logic [7:0] s, input logic [7:0] taps);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (taps[i]) p = p ^ s[i];
        end
        return {s[6:0], ~p};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        bus.en = 1'b0;  bus.load = 1'b0;  bus.seed = 8'h00;
        bus2.en = 1'b0; bus2.load = 1'b0; bus2.seed = 8'h00;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        bus.en = 1'b1; bus.load = 1'b1; bus.seed = 8'hA5;
        bus2.en = 1'b0; bus2.load = 1'b0; bus2.seed = 8'h00;
        RST = 1'b1;
        repeat (2) tick();
        checks++; if (bus.prs !== 8'h00) $display("FAIL reset_prs got=%h exp=00", bus.prs); else passes++;
        checks++; if (bus.prs_bit !== 1'b0) $display("FAIL reset_prs_bit got=%b exp=0", bus.prs_bit); else passes++;
        checks++; if (bus.wrap !== 1'b0 || bus.lockup !== 1'b0)
            $display("FAIL reset_pulses got wrap=%b lockup=%b exp 0 0", bus.wrap, bus.lockup); else passes++;
        checks++; if (bus.period !== 8'h00 || bus.period_valid !== 1'b0)
            $display("FAIL reset_period got=%h valid=%b exp 00 0", bus.period, bus.period_valid); else passes++;
        do_reset();
    endtask

    task automatic test_first_steps();
        logic [7:0] exp_tab [6];
        exp_tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D};
        do_reset();
        bus.en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus.prs !== exp_tab[i] || bus.prs_bit !== 1'b0)
                $display("FAIL first_steps[%0d] got prs=%h bit=%b exp prs=%h bit=0", i, bus.prs, bus.prs_bit, exp_tab[i]);
            else passes++;
        end
        bus.en = 1'b0;
    endtask

    task automatic test_full_period();
        logic [7:0] m;
        int ff_seen;
        do_reset();
        m = 8'h00; ff_seen = 0;
        bus.en = 1'b1;
        for (int s = 1; s <= 510; s++) begin
            tick();
            m = nxt(m, 8'hB8);
            if (bus.prs === 8'hFF) ff_seen++;
            checks++;
            if (bus.prs !== m || bus.wrap !== (s % 255 == 0))
                $display("FAIL full_period step %0d got prs=%h wrap=%b exp prs=%h wrap=%b",
                         s, bus.prs, bus.wrap, m, (s % 255 == 0));
            else passes++;
            if (s == 254) begin
                checks++;
                if (bus.period_valid !== 1'b0) $display("FAIL early_valid got=%b exp=0", bus.period_valid); else passes++;
            end
            if (s == 255 || s == 510) begin
                checks++;
                if (bus.period !== 8'd255 || bus.period_valid !== 1'b1 || bus.prs !== 8'h00)
                    $display("FAIL period_at_%0d got period=%0d valid=%b prs=%h exp 255 1 00",
                             s, bus.period, bus.period_valid, bus.prs);
                else passes++;
            end
        end
        bus.en = 1'b0;
        checks++; if (ff_seen !== 0) $display("FAIL all_ones_seen got=%0d exp=0", ff_seen); else passes++;
    endtask

    task automatic test_lockup();
        bus.load = 1'b1; bus.seed = 8'hFF; bus.en = 1'b0;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.prs !== 8'hFF || bus.lockup !== 1'b0 || bus.period_valid !== 1'b0)
            $display("FAIL lockup_seed got prs=%h lockup=%b valid=%b exp FF 0 0", bus.prs, bus.lockup, bus.period_valid);
        else passes++;
        bus.en = 1'b1;
        tick();
        checks++;
        if (bus.prs !== 8'h00 || bus.lockup !== 1'b1 || bus.period_valid !== 1'b0 || bus.wrap !== 1'b0)
            $display("FAIL lockup_escape got prs=%h lockup=%b valid=%b wrap=%b exp 00 1 0 0",
                     bus.prs, bus.lockup, bus.period_valid, bus.wrap);
        else passes++;
        tick();
        checks++;
        if (bus.prs !== 8'h01 || bus.lockup !== 1'b0)
            $display("FAIL lockup_after got prs=%h lockup=%b exp 01 0", bus.prs, bus.lockup);
        else passes++;
        bus.en = 1'b0;
    endtask

    task automatic test_load_midrun();
        logic [7:0] m;
        do_reset();
        bus.en = 1'b1;
        repeat (20) tick();
        bus.load = 1'b1; bus.seed = 8'h5A;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.prs !== 8'h5A || bus.wrap !== 1'b0 || bus.lockup !== 1'b0)
            $display("FAIL load_en got prs=%h wrap=%b lockup=%b exp 5A 0 0", bus.prs, bus.wrap, bus.lockup);
        else passes++;
        m = 8'h5A;
        for (int s = 1; s <= 255; s++) begin
            tick();
            m = nxt(m, 8'hB8);
            checks++;
            if (bus.prs !== m || bus.wrap !== (s == 255))
                $display("FAIL load_run step %0d got prs=%h wrap=%b exp prs=%h wrap=%b", s, bus.prs, bus.wrap, m, (s == 255));
            else passes++;
        end
        checks++;
        if (bus.prs !== 8'h5A || bus.period !== 8'd255 || bus.period_valid !== 1'b1)
            $display("FAIL load_wrap got prs=%h period=%0d valid=%b exp 5A 255 1", bus.prs, bus.period, bus.period_valid);
        else passes++;
        bus.en = 1'b0;
        tick();
        checks++;
        if (bus.wrap !== 1'b0 || bus.prs !== 8'h5A)
            $display("FAIL idle_hold got wrap=%b prs=%h exp 0 5A", bus.wrap, bus.prs);
        else passes++;
    endtask

    task automatic test_random_en();
        logic [7:0] m;
        logic e;
        int n;
        int cyc;
        do_reset();
        m = 8'h00; n = 0; cyc = 0;
        while (n < 255 && cyc < 2000) begin
            e = 1'($urandom_range(0, 1));
            bus.en = e;
            tick();
            cyc++;
            if (e) begin
                n++;
                m = nxt(m, 8'hB8);
            end
            checks++;
            if (bus.prs !== m || bus.wrap !== (e && n == 255))
                $display("FAIL random_en cyc %0d en=%b got prs=%h wrap=%b exp prs=%h wrap=%b",
                         cyc, e, bus.prs, bus.wrap, m, (e && n == 255));
            else passes++;
        end
        bus.en = 1'b0;
        checks++;
        if (n !== 255 || bus.period !== 8'd255 || bus.period_valid !== 1'b1)
            $display("FAIL random_en_end got steps=%0d period=%0d valid=%b exp 255 255 1", n, bus.period, bus.period_valid);
        else passes++;
    endtask

    task automatic test_taps_0c();
        logic [7:0] exp_tab [4];
        logic [7:0] m;
        exp_tab = '{8'h01, 8'h03, 8'h07, 8'h0E};
        do_reset();
        m = 8'h00;
        bus2.en = 1'b1;
        for (int s = 1; s <= 300; s++) begin
            tick();
            m = nxt(m, 8'h0C);
            if (s <= 4) begin
                checks++;
                if (bus2.prs !== exp_tab[s-1])
                    $display("FAIL taps0c_first[%0d] got=%h exp=%h", s, bus2.prs, exp_tab[s-1]);
                else passes++;
            end
            checks++;
            if (bus2.prs !== m || bus2.wrap !== 1'b0 || bus2.lockup !== 1'b0)
                $display("FAIL taps0c step %0d got prs=%h wrap=%b lockup=%b exp prs=%h 0 0",
                         s, bus2.prs, bus2.wrap, bus2.lockup, m);
            else passes++;
        end
        checks++;
        if (bus2.period_valid !== 1'b0 || bus2.period !== 8'h00)
            $display("FAIL taps0c_period got period=%h valid=%b exp 00 0", bus2.period, bus2.period_valid);
        else passes++;
        checks++;
        if (dut2.cnt_r !== 8'hFF) $display("FAIL taps0c_cnt_sat got=%h exp=FF", dut2.cnt_r); else passes++;
        // Reset well away from any clock edge: outputs must clear without waiting for CLK.
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (bus2.prs !== 8'h00 || bus2.prs_bit !== 1'b0 || bus2.wrap !== 1'b0 ||
            bus2.lockup !== 1'b0 || bus2.period_valid !== 1'b0 || bus2.period !== 8'h00)
            $display("FAIL async_reset got prs=%h bit=%b wrap=%b lockup=%b valid=%b period=%h exp all 0",
                     bus2.prs, bus2.prs_bit, bus2.wrap, bus2.lockup, bus2.period_valid, bus2.period);
        else passes++;
        checks++;
        if (dut2.cnt_r !== 8'h00) $display("FAIL async_reset_cnt got=%h exp=00", dut2.cnt_r); else passes++;
        bus2.en = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_steps();
        test_full_period();
        test_lockup();
        test_load_midrun();
        test_random_en();
        test_taps_0c();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
